dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory side of the MEM-stage data port. Accepts
//  word-aligned load/store requests (address, merged write word, write enable),
//  applies a programmable wait-state count and returns read data with a
//  one-cycle ready pulse. Sub-word merge and extension stay in the MEM stage;
//  this block only stores and returns whole 32-bit words.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words in the array (power of 2)
//  ADDR_BASE    32'h1001_0000 byte address of word 0
//  WAIT_CYCLES  1             extra cycles between accept and ready (0..15)
// PORTS
//  i_clk       in   1   clock; all state changes on rising edge
//  i_rst       in   1   synchronous, active-high reset
//  i_req       in   1   request valid; held by the initiator until o_ready
//  i_wena      in   1   1 = store, 0 = load; sampled on accept
//  i_addr      in   32  byte address; sampled on accept
//  i_wdata     in   32  store word; sampled on accept
//  o_rdata     out  32  load data; valid while o_ready=1, held until next load
//  o_ready     out  1   one-cycle completion pulse
//  o_busy      out  1   1 whenever state != IDLE
//  o_addr_err  out  1   qualifies o_ready: access rejected (range/alignment)
// BEHAVIOUR
//  Reset: state=IDLE, o_rdata=0, o_ready=0, o_busy=0, o_addr_err=0, counter=0.
//   Array contents are not cleared by reset.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: i_req=1 -> latch i_wena/i_addr/i_wdata; if WAIT_CYCLES=0 go RESP,
//    else load counter=WAIT_CYCLES-1 and go WAIT. i_req=0 -> stay.
//   WAIT: counter!=0 -> decrement; counter=0 -> go RESP.
//   RESP: perform access on latched values, o_ready=1 for this cycle only,
//    next state IDLE.
//  Latency: accept edge to o_ready = WAIT_CYCLES+1 cycles.
//  Request accepted only in IDLE; the cycle after o_ready is always IDLE, so
//   a held i_req re-issues there (min 2 cycles per access with WAIT_CYCLES=0).
//   i_req/data changes while busy are ignored.
//  Address check on latched address: err = addr[1:0]!=0 OR addr<ADDR_BASE OR
//   addr >= ADDR_BASE+4*DEPTH_WORDS (unsigned, 33-bit compare, no wrap).
//  Index = (addr-ADDR_BASE)>>2, log2(DEPTH_WORDS) bits.
//  RESP, store, no err: array[index] <= wdata; o_rdata unchanged.
//  RESP, load, no err: o_rdata = array[index] (registered from array contents
//   at the RESP edge, includes all prior completed stores).
//  RESP with err: no array write; o_rdata=0; o_addr_err=1 with o_ready.
//  o_addr_err is 0 whenever o_ready is 0.
//  Reset in WAIT or RESP: access aborted, no write committed, outputs to reset
//   values next edge.
// TESTING
//  1 WAIT_CYCLES=1: store 0xDEADBEEF @0x10010004, then load same -> o_ready 2
//    cycles after each accept; load o_rdata=0xDEADBEEF, o_addr_err=0.
//  2 WAIT_CYCLES=0: hold i_req for 4 back-to-back loads -> o_ready every 2nd
//    cycle, o_busy toggles 1,0.
//  3 Load @0x10010002 (misaligned) and @0x10011000 (DEPTH 1024, past end) ->
//    o_ready with o_addr_err=1, o_rdata=0; prior store to word 0 unchanged.
//  4 WAIT_CYCLES=3: change i_addr/i_wdata mid-WAIT -> latched values used;
//    o_ready exactly 4 cycles after accept.
//  5 Store 0x12345678 @0x10010008, assert i_rst in WAIT -> later load of
//    0x10010008 returns old value; o_ready/o_busy 0 the cycle after reset.
//  6 Load then store to different word -> o_rdata holds load value through
//    store's o_ready pulse.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory side of the MEM-stage data port. Accepts one word-aligned load or
// store at a time, waits a fixed number of cycles, then performs the access
// and signals completion with a single-cycle o_ready pulse. Only whole
// 32-bit words are stored and returned; byte/half merging and sign or zero
// extension are done by the requester.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the array (power of two)
//   ADDR_BASE    byte address of word 0 (word aligned)
//   WAIT_CYCLES  extra cycles between accept and ready (0..15)
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_req       request valid, held by the initiator until o_ready
//   i_wena      1 = store, 0 = load, sampled on accept
//   i_addr      byte address, sampled on accept
//   i_wdata     store word, sampled on accept
//   o_rdata     load data, valid with o_ready, held until the next load
//   o_ready     one-cycle completion pulse
//   o_busy      high whenever the FSM is not idle
//   o_addr_err  qualifies o_ready: access rejected (range or alignment)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wena,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  // One past the last valid byte address, kept at 33 bits so an array that
  // ends exactly at 4 GiB does not wrap to zero.
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) * 33'd4);

  // Value loaded into the wait counter on accept. The counter counts down to
  // zero while in WAIT, so the WAIT state lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        lat_wena;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  count;

  logic              accept;
  logic              addr_err;
  logic [IDX_W-1:0]  index;
  logic              do_write;
  logic              do_read;

  logic [31:0] mem [DEPTH_WORDS];

  // A new request is only taken while idle; anything on the request side
  // during WAIT or RESP is ignored.
  assign accept = (state == IDLE) && i_req;

  // Range and alignment check on the latched address. Both comparisons are
  // unsigned and done at 33 bits.
  assign addr_err = (lat_addr[1:0] != 2'b00)
                 || ({1'b0, lat_addr} < {1'b0, ADDR_BASE})
                 || ({1'b0, lat_addr} >= ADDR_LIMIT);

  // Word index relative to the base. Because ADDR_BASE is word aligned and
  // in-range addresses are aligned, subtracting only the index-width slice
  // of the word address gives (addr - ADDR_BASE) >> 2 without a full-width
  // subtractor. Out-of-range addresses produce a meaningless index, but
  // addr_err blocks any access with them.
  assign index = IDX_W'(lat_addr[IDX_W+1:2] - ADDR_BASE[IDX_W+1:2]);

  // Array access happens only on the RESP edge. A reset on that same edge
  // aborts the access so nothing is committed.
  assign do_write = (state == RESP) && lat_wena  && !addr_err && !i_rst;
  assign do_read  = (state == RESP) && !lat_wena && !addr_err;

  assign o_busy = (state != IDLE);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_req) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture and wait counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_wena  <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      count     <= 4'd0;
    end else begin
      if (accept) begin
        lat_wena  <= i_wena;
        lat_addr  <= i_addr;
        lat_wdata <= i_wdata;
        count     <= WAIT_LOAD;
      end else if ((state == WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
    end
  end

  // Storage array. Deliberately not reset: contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      mem[index] <= lat_wdata;
    end
  end

  // Registered response. o_ready and o_addr_err rise on the RESP edge, so
  // they are seen during the following (IDLE) cycle together with o_rdata.
  // Stores leave o_rdata holding the last loaded word; rejected accesses
  // clear it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata    <= 32'd0;
      o_ready    <= 1'b0;
      o_addr_err <= 1'b0;
    end else begin
      o_ready    <= (state == RESP);
      o_addr_err <= (state == RESP) && addr_err;
      if ((state == RESP) && addr_err) begin
        o_rdata <= 32'd0;
      end else if (do_read) begin
        o_rdata <= mem[index];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders with WAIT_CYCLES of 1, 0 and 3 run side by side on one
// clock. Each request pushes its expected response into a per-instance queue;
// a monitor pops and compares whenever an instance raises o_ready.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          NDUT = 3;

  logic        clk = 1'b0;
  logic        rst      [NDUT];
  logic        req      [NDUT];
  logic        wena     [NDUT];
  logic [31:0] addr     [NDUT];
  logic [31:0] wdata    [NDUT];
  logic [31:0] rdata    [NDUT];
  logic        ready    [NDUT];
  logic        busy     [NDUT];
  logic        addr_err [NDUT];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q [NDUT][$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=0, instance 2: WAIT_CYCLES=3
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (1024),
      .ADDR_BASE   (32'h1001_0000),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst[g]),
      .i_req      (req[g]),
      .i_wena     (wena[g]),
      .i_addr     (addr[g]),
      .i_wdata    (wdata[g]),
      .o_rdata    (rdata[g]),
      .o_ready    (ready[g]),
      .o_busy     (busy[g]),
      .o_addr_err (addr_err[g])
    );
  end

  function automatic int wait_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act === exp_v) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Monitor: every o_ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (ready[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_ready dut%0d: got o_ready=1, expected no response", d);
        end else begin
          e = exp_q[d].pop_front();
          check_output($sformatf("rdata dut%0d", d), rdata[d], e.rdata);
          check_output($sformatf("addr_err dut%0d", d), {31'd0, addr_err[d]}, {31'd0, e.err});
        end
      end else if (addr_err[d] !== 1'b0) begin
        check_output($sformatf("addr_err_without_ready dut%0d", d), {31'd0, addr_err[d]}, 32'd0);
      end
    end
  end

  // Issue one access on instance d. abort asserts reset one cycle after the
  // accept (WAIT for WAIT_CYCLES=1, RESP for WAIT_CYCLES=0). scramble changes
  // the request inputs while the access is in flight.
  task automatic apply_stimulus(int d, bit is_store, logic [31:0] a, logic [31:0] w,
                                logic [31:0] exp_rdata, bit exp_err,
                                bit abort = 1'b0, bit scramble = 1'b0);
    int   n;
    bit   seen;
    exp_t e;
    @(negedge clk);
    req[d]   = 1'b1;
    wena[d]  = is_store;
    addr[d]  = a;
    wdata[d] = w;
    if (!abort) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q[d].push_back(e);
    end
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    if (abort) begin
      rst[d] = 1'b1;
      @(posedge clk);
      #1;
      rst[d] = 1'b0;
      check_output($sformatf("abort_ready dut%0d", d), {31'd0, ready[d]}, 32'd0);
      check_output($sformatf("abort_busy dut%0d", d), {31'd0, busy[d]}, 32'd0);
      check_output($sformatf("abort_rdata dut%0d", d), rdata[d], 32'd0);
      return;
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (scramble && n == 1) begin
        addr[d]  = a ^ 32'h4;
        wdata[d] = ~w;
        wena[d]  = ~is_store;
      end
      @(posedge clk);
      n++;
      #1;
      if (ready[d] === 1'b1) seen = 1'b1;
    end
    check_output($sformatf("latency dut%0d addr 0x%08h", d, a), n, wait_of(d) + 1);
  endtask

  // Four loads with i_req held high on the zero-wait instance.
  task automatic burst_loads(int d);
    logic [31:0] a [4];
    logic [31:0] v [4];
    exp_t        e;
    int          k;
    a = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC};
    v = '{32'h1, 32'h2, 32'h3, 32'h4};
    for (int i = 0; i < 4; i++) begin
      e.rdata = v[i];
      e.err   = 1'b0;
      exp_q[d].push_back(e);
    end
    @(negedge clk);
    req[d]  = 1'b1;
    wena[d] = 1'b0;
    addr[d] = a[0];
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("burst_busy c%0d", c), {31'd0, busy[d]}, {31'd0, (c % 2 == 0)});
      check_output($sformatf("burst_ready c%0d", c), {31'd0, ready[d]}, {31'd0, (c % 2 == 1)});
      if (c % 2 == 1) begin
        if (k < 3) addr[d] = a[k + 1];
        else       req[d]  = 1'b0;
        k++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d]   = 1'b1;
      req[d]   = 1'b0;
      wena[d]  = 1'b0;
      addr[d]  = 32'd0;
      wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      check_output($sformatf("reset_rdata dut%0d", d), rdata[d], 32'd0);
      check_output($sformatf("reset_ready dut%0d", d), {31'd0, ready[d]}, 32'd0);
      check_output($sformatf("reset_busy dut%0d", d), {31'd0, busy[d]}, 32'd0);
      check_output($sformatf("reset_addr_err dut%0d", d), {31'd0, addr_err[d]}, 32'd0);
    end

    // Instance 0 (one wait state)
    apply_stimulus(0, 1, BASE + 32'h4,    32'hDEAD_BEEF, 32'h0000_0000, 0);
    apply_stimulus(0, 0, BASE + 32'h4,    32'h0,         32'hDEAD_BEEF, 0);
    apply_stimulus(0, 1, BASE,            32'hA5A5_A5A5, 32'hDEAD_BEEF, 0);
    apply_stimulus(0, 0, BASE + 32'h2,    32'h0,         32'h0000_0000, 1);
    apply_stimulus(0, 0, BASE + 32'h1000, 32'h0,         32'h0000_0000, 1);
    apply_stimulus(0, 0, BASE - 32'h4,    32'h0,         32'h0000_0000, 1);
    apply_stimulus(0, 0, BASE,            32'h0,         32'hA5A5_A5A5, 0);
    apply_stimulus(0, 1, BASE + 32'h10,   32'h0BAD_F00D, 32'hA5A5_A5A5, 0);
    apply_stimulus(0, 1, BASE + 32'h8,    32'h1111_2222, 32'hA5A5_A5A5, 0);
    apply_stimulus(0, 1, BASE + 32'h8,    32'h1234_5678, 32'h0,         0, 1'b1);
    apply_stimulus(0, 0, BASE + 32'h8,    32'h0,         32'h1111_2222, 0);
    apply_stimulus(0, 1, BASE + 32'hFFC,  32'h7777_8888, 32'h1111_2222, 0);
    apply_stimulus(0, 0, BASE + 32'hFFC,  32'h0,         32'h7777_8888, 0);
    apply_stimulus(0, 1, BASE + 32'h6,    32'hEEEE_EEEE, 32'h0000_0000, 1);
    apply_stimulus(0, 0, BASE + 32'h4,    32'h0,         32'hDEAD_BEEF, 0);

    // Instance 1 (no wait states)
    apply_stimulus(1, 1, BASE,            32'h1,         32'h0, 0);
    apply_stimulus(1, 1, BASE + 32'h4,    32'h2,         32'h0, 0);
    apply_stimulus(1, 1, BASE + 32'h8,    32'h3,         32'h0, 0);
    apply_stimulus(1, 1, BASE + 32'hC,    32'h4,         32'h0, 0);
    burst_loads(1);
    apply_stimulus(1, 1, BASE,            32'h9999_9999, 32'h0, 0, 1'b1);
    apply_stimulus(1, 0, BASE,            32'h0,         32'h1, 0);

    // Instance 2 (three wait states, inputs disturbed mid-wait)
    apply_stimulus(2, 1, BASE + 32'h14,   32'h0,         32'h0, 0);
    apply_stimulus(2, 1, BASE + 32'h10,   32'hCAFE_F00D, 32'h0, 0, 1'b0, 1'b1);
    apply_stimulus(2, 0, BASE + 32'h10,   32'h0,         32'hCAFE_F00D, 0);
    apply_stimulus(2, 0, BASE + 32'h14,   32'h0,         32'h0, 0, 1'b0, 1'b1);

    repeat (10) @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (exp_q[d].size() != 0) begin
        checks++;
        $display("[TB] FAIL missing_response dut%0d: got %0d outstanding, expected 0", d, exp_q[d].size());
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
